// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling datapath.
package rc4_pkg;

  localparam int unsigned S_SIZE            = 256;
  localparam int unsigned KEY_BYTES_DEFAULT = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_CALC,
    ST_SWAP,
    ST_NEXT,
    ST_DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_index_fsm_if.sv
// S-memory read port and swap-FSM handshake seen by the KSA index controller.
interface ksa_index_fsm_if;
  import rc4_pkg::*;

  byte_t s_addr;
  byte_t s_q;
  byte_t counter_i;
  byte_t counter_j;
  logic  swap_flag;
  logic  swap_done;

  modport master (
    output s_addr, counter_i, counter_j, swap_flag,
    input  s_q, swap_done
  );

  modport slave (
    input  s_addr, counter_i, counter_j, swap_flag,
    output s_q, swap_done
  );

endinterface

// File: rtl/ksa_index_fsm_key_sel.sv
// Key register plus a mod-KEY_BYTES byte pointer; byte 0 is the key MSB.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   advance,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output byte_t                  key_byte_c
);

  localparam int unsigned IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned KEY_W = 8 * KEY_BYTES;

  logic [KEY_W-1:0] key_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      key_q <= secret_key;
      idx_q <= '0;
    end else if (advance) begin
      idx_q <= (idx_q == IDX_W'(KEY_BYTES - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
    end
  end

  // Byte select as a flat mux so no divider or variable shifter is built.
  always_comb begin
    key_byte_c = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) key_byte_c = key_q[KEY_W-8-8*k +: 8];
    end
  end

endmodule

// File: rtl/ksa_index_fsm.sv
// RC4 key-scheduling index controller: walks i over S, accumulates j and
// requests one swap per i from the downstream swap FSM.
module ksa_index_fsm
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES    = KEY_BYTES_DEFAULT,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   ksa_done,
  ksa_index_fsm_if.master        bus
);

  localparam int unsigned WAIT_W = 2;
  localparam byte_t       I_LAST = 8'(S_SIZE - 1);

  ksa_state_t        state, state_n;
  byte_t             i_q, i_n, j_q, j_n, s_addr_q, s_addr_n;
  logic [WAIT_W-1:0] wait_q, wait_n;
  logic              swap_flag_q, swap_flag_n;
  logic              busy_n, done_n;
  logic              load_key, adv_key;
  byte_t             key_byte_c;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_key),
    .advance    (adv_key),
    .secret_key (secret_key),
    .key_byte_c (key_byte_c)
  );

  assign bus.s_addr    = s_addr_q;
  assign bus.counter_i = i_q;
  assign bus.counter_j = j_q;
  assign bus.swap_flag = swap_flag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      s_addr_q    <= '0;
      wait_q      <= '0;
      swap_flag_q <= 1'b0;
      busy        <= 1'b0;
      ksa_done    <= 1'b0;
    end else begin
      state       <= state_n;
      i_q         <= i_n;
      j_q         <= j_n;
      s_addr_q    <= s_addr_n;
      wait_q      <= wait_n;
      swap_flag_q <= swap_flag_n;
      busy        <= busy_n;
      ksa_done    <= done_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n  = state;
    i_n      = i_q;
    j_n      = j_q;
    s_addr_n = s_addr_q;
    wait_n   = wait_q;
    load_key = 1'b0;
    adv_key  = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_key = 1'b1;
          i_n      = '0;
          j_n      = '0;
          s_addr_n = '0;
          state_n  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        wait_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(READ_LATENCY - 1)) state_n = ST_CALC;
        else                                     wait_n  = WAIT_W'(wait_q + 1'b1);
      end
      ST_CALC: begin
        j_n     = 8'(j_q + bus.s_q + key_byte_c);
        state_n = ST_SWAP;
      end
      ST_SWAP: begin
        if (bus.swap_done) state_n = ST_NEXT;
      end
      ST_NEXT: begin
        if (i_q == I_LAST) begin
          state_n = ST_DONE;
        end else begin
          i_n      = 8'(i_q + 8'd1);
          s_addr_n = 8'(i_q + 8'd1);
          adv_key  = 1'b1;
          state_n  = ST_ADDR;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Flag levels follow the state being entered so they are pure registers.
    swap_flag_n = (state_n == ST_SWAP);
    busy_n      = (state_n != ST_IDLE) && (state_n != ST_DONE);
    done_n      = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_ksa_index_fsm.sv
// Self-checking bench: S-memory + swap FSM model, software KSA scoreboard.
`timescale 1ns/1ps
module tb_ksa_index_fsm;
  import rc4_pkg::*;

  localparam int unsigned KB = 3;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          start      = 1'b0;
  logic [23:0]   secret_key = '0;
  logic          busy, ksa_done;

  ksa_index_fsm_if bus();

  ksa_index_fsm #(.KEY_BYTES(KB), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .busy(busy), .ksa_done(ksa_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  byte_t       mem[256];
  byte_t       model_s[256];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          rise_cnt = 0;
  int          stab_err = 0;
  int          delay_mode = 2;   // fixed swap_done delay, or -1 for random 0..20
  bit          spurious_req = 1'b0;

  // Swap FSM + S-memory model: swaps on swap_done, read data one cycle late.
  initial begin : responder
    int rem;
    byte_t t;
    rem = -1;
    bus.swap_done = 1'b0;
    bus.s_q = '0;
    forever begin
      @(posedge clk); #1;
      bus.swap_done = 1'b0;
      if (!reset_n) begin
        rem = -1;
      end else if (spurious_req) begin
        spurious_req  = 1'b0;
        bus.swap_done = 1'b1;
      end else if (bus.swap_flag) begin
        if (rem < 0) rem = (delay_mode < 0) ? int'($urandom_range(20, 0)) : delay_mode;
        if (rem == 0) begin
          t = mem[bus.counter_i];
          mem[bus.counter_i] = mem[bus.counter_j];
          mem[bus.counter_j] = t;
          bus.swap_done = 1'b1;
          rem = -1;
        end else begin
          rem--;
        end
      end
      bus.s_q = mem[bus.s_addr];
    end
  end

  // Records each swap request and flags counter/flag instability.
  initial begin : monitor
    logic  prev;
    byte_t ci, cj;
    bit    got_done;
    prev = 1'b0; ci = '0; cj = '0; got_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.swap_flag && !prev) begin
          rise_cnt++;
          obs_q.push_back({bus.counter_i, bus.counter_j});
          ci = bus.counter_i; cj = bus.counter_j; got_done = 1'b0;
        end else if (bus.swap_flag && (bus.counter_i !== ci || bus.counter_j !== cj)) begin
          stab_err++;
        end
        if (bus.swap_flag && bus.swap_done) got_done = 1'b1;
        if (!bus.swap_flag && prev && !got_done) stab_err++;
      end
      prev = reset_n ? bus.swap_flag : 1'b0;
    end
  end

  task automatic model_ksa(input logic [23:0] key);
    byte_t s[256];
    byte_t j, t;
    byte_t kb[3];
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = '0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      j = 8'(j + s[i] + kb[i % 3]);
      exp_q.push_back({8'(i), j});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    model_s = s;
  endtask

  task automatic prep_run(input logic [23:0] key);
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    model_ksa(key);
    obs_q.delete();
    rise_cnt = 0;
    stab_err = 0;
  endtask

  task automatic begin_run(input logic [23:0] key);
    prep_run(key);
    @(posedge clk); #1;
    secret_key = key;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (ksa_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [15:0] e, o;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.swap_flag, busy, ksa_done, bus.counter_i, bus.counter_j, bus.s_addr} !== 27'h0) begin
      bad++;
      $display("FAIL reset_state got=%b_%b_%b_%h_%h_%h expected=all zero",
               bus.swap_flag, busy, ksa_done, bus.counter_i, bus.counter_j, bus.s_addr);
    end
    reset_n = 1'b1;
    delay_mode = 2;
    begin_run(24'h000249);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clk);
      if (bus.swap_flag && bus.counter_i == 8'h40) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reset_reach_i40 got=timeout expected=swap_flag at i=40"); end
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.swap_flag, busy, ksa_done} !== 3'b000) begin
      bad++; $display("FAIL reset_mid_flags got=%b%b%b expected=000", bus.swap_flag, busy, ksa_done);
    end
    total++;
    if ({bus.counter_i, bus.counter_j} !== 16'h0000) begin
      bad++; $display("FAIL reset_mid_counters got=%h_%h expected=00_00", bus.counter_i, bus.counter_j);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    begin_run(24'h000249);
    wait_done(20000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_rerun_done got=timeout expected=ksa_done"); end
    total++;
    if (rise_cnt !== 256) begin bad++; $display("FAIL reset_rerun_count got=%0d expected=256", rise_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL reset_rerun_sb got=none expected=%h", e); break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL reset_rerun_sb got=%h expected=%h", o, e); end
    end
  endtask

  task automatic test_known_key();
    bit ok;
    int nm;
    logic [15:0] e, o, last;
    delay_mode = 2;
    begin_run(24'h000249);
    wait_done(20000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL key0249_done got=timeout expected=ksa_done"); end
    total++;
    if (obs_q.size() < 3) begin
      bad++; $display("FAIL key0249_first3 got=%0d requests expected>=3", obs_q.size());
    end else if (obs_q[0][7:0] !== 8'h00 || obs_q[1][7:0] !== 8'h03 || obs_q[2][7:0] !== 8'h4E) begin
      bad++; $display("FAIL key0249_first3 got=%h,%h,%h expected=00,03,4e",
                      obs_q[0][7:0], obs_q[1][7:0], obs_q[2][7:0]);
    end
    total++;
    if (rise_cnt !== 256) begin bad++; $display("FAIL key0249_count got=%0d expected=256", rise_cnt); end
    last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 16'h0;
    total++;
    if (last[15:8] !== 8'hFF || busy !== 1'b0 || ksa_done !== 1'b1) begin
      bad++; $display("FAIL key0249_end got=last_i=%h busy=%b done=%b expected=ff,0,1", last[15:8], busy, ksa_done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL key0249_sb got=none expected=%h", e); break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL key0249_sb got=%h expected=%h", o, e); end
    end
    nm = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) nm++;
    total++;
    if (nm != 0) begin bad++; $display("FAIL key0249_final_s got=%0d wrong entries expected=0", nm); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] e, o;
    delay_mode = 0;
    begin_run(24'hFFFFFF);
    wait_done(20000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_done got=timeout expected=ksa_done"); end
    total++;
    if (obs_q.size() < 2) begin
      bad++; $display("FAIL wrap_first2 got=%0d requests expected>=2", obs_q.size());
    end else if (obs_q[0] !== 16'h00FF || obs_q[1] !== 16'h01FF) begin
      bad++; $display("FAIL wrap_first2 got=%h,%h expected=00ff,01ff", obs_q[0], obs_q[1]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL wrap_sb got=none expected=%h", e); break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL wrap_sb got=%h expected=%h", o, e); end
    end
  endtask

  task automatic test_handshake_stress();
    bit ok;
    logic [15:0] e, o;
    @(posedge clk); #3 reset_n = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    @(negedge clk); spurious_req = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, bus.swap_flag, ksa_done, bus.counter_i} !== 11'h0) begin
      bad++; $display("FAIL spurious_idle got=%b%b%b_%h expected=000_00", busy, bus.swap_flag, ksa_done, bus.counter_i);
    end
    delay_mode = -1;
    prep_run(24'h000249);
    @(posedge clk); #1;
    secret_key = 24'h000249;
    start = 1'b1;
    @(negedge clk); spurious_req = 1'b1;   // lands on the first ADDR cycle
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stress_done got=timeout expected=ksa_done"); end
    total++;
    if (stab_err !== 0) begin bad++; $display("FAIL stress_stable got=%0d violations expected=0", stab_err); end
    total++;
    if (rise_cnt !== 256) begin bad++; $display("FAIL stress_count got=%0d expected=256", rise_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL stress_sb got=none expected=%h", e); break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL stress_sb got=%h expected=%h", o, e); end
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    logic [15:0] e, o;
    delay_mode = 1;
    begin_run(24'h000249);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clk);
      if (bus.counter_i == 8'h10) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL busy_reach_i10 got=timeout expected=i=10"); end
    @(posedge clk); #1;
    secret_key = 24'hABCDEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || bus.counter_i !== 8'h10) begin
      bad++; $display("FAIL busy_start_ignored got=busy=%b i=%h expected=1,10", busy, bus.counter_i);
    end
    wait_done(20000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL busy_run_done got=timeout expected=ksa_done"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL busy_sb got=none expected=%h", e); break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL busy_sb got=%h expected=%h", o, e); end
    end
    begin_run(24'h123456);
    total++;
    if (ksa_done !== 1'b0 || busy !== 1'b1 || bus.counter_j !== 8'h00) begin
      bad++; $display("FAIL restart_in_done got=done=%b busy=%b j=%h expected=0,1,00", ksa_done, busy, bus.counter_j);
    end
    wait_done(20000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL restart_done got=timeout expected=ksa_done"); end
    total++;
    if (obs_q.size() == 0 || obs_q[0] !== 16'h0012) begin
      bad++; $display("FAIL restart_first_j got=%h expected=0012", (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL restart_sb got=none expected=%h", e); break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL restart_sb got=%h expected=%h", o, e); end
    end
  endtask

  initial begin : main
    test_reset();
    test_known_key();
    test_wrap();
    test_handshake_stress();
    test_busy_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
